// File: rtl/seven_seg_receiver.sv
// Receiving end of the 7-segment serial display link.
// Rebuilds 16-bit frames {segments, select} from the data/latch lines, decodes each
// frame to a digit position and BCD value, and after an in-order 3..0 scan outputs
// the reconstructed binary number.
module seven_seg_receiver #(
  parameter int unsigned SEG_ACTIVE_LOW = 0,
  parameter int unsigned FRAME_BITS     = 16
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_Data,
  input  logic        i_Latch,
  output logic        o_Frame_Valid,
  output logic [1:0]  o_Digit_Sel,
  output logic [7:0]  o_Segments,
  output logic [3:0]  o_BCD,
  output logic [13:0] o_Value,
  output logic        o_Value_Valid,
  output logic        o_Frame_Err,
  output logic        o_Decode_Err
);

  localparam logic [3:0] LastBit = 4'(FRAME_BITS - 1);

  typedef enum logic {StSync, StShift} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [15:0]       sr_q, sr_d;
  logic              frame_done, frame_bad;

  logic [15:0]       frame_w;
  logic [7:0]        seg_eff;
  logic              sel_ok, seg_ok, good;
  logic [1:0]        digit;
  logic [3:0]        bcd;

  logic [1:0]        expect_q, expect_d;
  logic [3:0][3:0]   dig_q, dig_d;
  logic              scan_done_q, scan_done_d;

  logic              frame_valid_q, frame_err_q, decode_err_q, value_valid_q;
  logic [1:0]        digit_sel_q;
  logic [7:0]        segments_q;
  logic [3:0]        bcd_q;
  logic [13:0]       value_q;

  // State register for the framing FSM.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) state_q <= StSync;
    else       state_q <= state_d;
  end

  // Next state: leave SYNC on a latch-low; fall back to SYNC on a missing end marker.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSync:  if (!i_Latch) state_d = StShift;
      StShift: if (i_Latch && (cnt_q == LastBit)) state_d = StSync;
      default: state_d = StSync;
    endcase
  end

  // FSM outputs: shift/count control and frame-complete / framing-error strobes.
  always_comb begin
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    frame_done = 1'b0;
    frame_bad  = 1'b0;
    unique case (state_q)
      StSync: cnt_d = 4'd0;
      StShift: begin
        sr_d = {i_Data, sr_q[15:1]};
        if (!i_Latch) begin
          // Latch low always realigns the bit counter.
          cnt_d = 4'd0;
          if (cnt_q == LastBit) frame_done = 1'b1;
          else                  frame_bad  = 1'b1;
        end else if (cnt_q == LastBit) begin
          cnt_d     = 4'd0;
          frame_bad = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: cnt_d = 4'd0;
    endcase
  end

  // Shift register and bit counter.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      cnt_q <= 4'd0;
      sr_q  <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

  // Decode the frame as it completes, including the bit arriving this cycle.
  always_comb begin
    frame_w = {i_Data, sr_q[15:1]};
    seg_eff = (SEG_ACTIVE_LOW != 0) ? ~frame_w[15:8] : frame_w[15:8];
    sel_ok  = 1'b1;
    digit   = 2'd0;
    case (frame_w[7:0])
      8'h04:   digit = 2'd3;
      8'h08:   digit = 2'd2;
      8'h20:   digit = 2'd1;
      8'h40:   digit = 2'd0;
      default: sel_ok = 1'b0;
    endcase
    seg_ok = 1'b1;
    bcd    = 4'd0;
    // Decimal point (bit 7) is ignored.
    case (seg_eff[6:0])
      7'h3F:   bcd = 4'd0;
      7'h06:   bcd = 4'd1;
      7'h5B:   bcd = 4'd2;
      7'h4F:   bcd = 4'd3;
      7'h66:   bcd = 4'd4;
      7'h6D:   bcd = 4'd5;
      7'h7D:   bcd = 4'd6;
      7'h07:   bcd = 4'd7;
      7'h7F:   bcd = 4'd8;
      7'h6F:   bcd = 4'd9;
      default: seg_ok = 1'b0;
    endcase
    good = frame_done && sel_ok && seg_ok;
  end

  // Scan tracker: accept digits 3,2,1,0 in order; any disturbance restarts at 3.
  always_comb begin
    expect_d    = expect_q;
    dig_d       = dig_q;
    scan_done_d = 1'b0;
    if (frame_bad || (frame_done && !good)) begin
      expect_d = 2'd3;
    end else if (good) begin
      if (digit == expect_q) begin
        dig_d[digit] = bcd;
        if (digit == 2'd0) begin
          expect_d    = 2'd3;
          scan_done_d = 1'b1;
        end else begin
          expect_d = expect_q - 2'd1;
        end
      end else if (digit == 2'd3) begin
        // Out-of-order thousands digit starts a fresh scan.
        dig_d[3] = bcd;
        expect_d = 2'd2;
      end else begin
        expect_d = 2'd3;
      end
    end
  end

  // Frame outputs, error pulses, scan state and the registered multiply-add.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      decode_err_q  <= 1'b0;
      digit_sel_q   <= 2'd0;
      segments_q    <= 8'd0;
      bcd_q         <= 4'd0;
      expect_q      <= 2'd3;
      dig_q         <= '0;
      scan_done_q   <= 1'b0;
      value_q       <= 14'd0;
      value_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= good;
      frame_err_q   <= frame_bad;
      decode_err_q  <= frame_done && !good;
      if (good) begin
        digit_sel_q <= digit;
        segments_q  <= frame_w[15:8];
        bcd_q       <= bcd;
      end
      expect_q      <= expect_d;
      dig_q         <= dig_d;
      scan_done_q   <= scan_done_d;
      value_valid_q <= scan_done_q;
      if (scan_done_q) begin
        value_q <= 14'(dig_q[3]) * 14'd1000 + 14'(dig_q[2]) * 14'd100
                 + 14'(dig_q[1]) * 14'd10 + 14'(dig_q[0]);
      end
    end
  end

  assign o_Frame_Valid = frame_valid_q;
  assign o_Frame_Err   = frame_err_q;
  assign o_Decode_Err  = decode_err_q;
  assign o_Digit_Sel   = digit_sel_q;
  assign o_Segments    = segments_q;
  assign o_BCD         = bcd_q;
  assign o_Value       = value_q;
  assign o_Value_Valid = value_valid_q;

endmodule

// File: doc/seven_seg_receiver.md
Name: seven_seg_receiver

Overview:
- Receiving end of the 7-segment serial display link. Samples the one-bit data line and the active-low latch line and rebuilds each 16-bit frame: an 8-bit digit-select byte plus an 8-bit segment byte.
- Decodes each frame to a digit position and a BCD value.
- After a full in-order 4-digit scan, outputs the reconstructed binary number.
- Used for display loopback self-test on the Spartan6 board and as a bench monitor for the display driver.

Parameters:
- SEG_ACTIVE_LOW, 0, 1 = segment byte is inverted before decode.
- FRAME_BITS, 16, bits per frame; the RTL supports only 16.

Ports:
- i_CLK  input  1  system clock; one serial bit per rising edge.
- i_RST  input  1  asynchronous, active-high reset.
- i_Data  input  1  serial data, LSB of the frame first.
- i_Latch  input  1  high for frame bits 0..14, low on bit 15 (end-of-frame marker).
- o_Frame_Valid  output  1  one-cycle pulse: a good frame was decoded.
- o_Digit_Sel  output  2  digit index of the last good frame: 3=thousands, 2=hundreds, 1=tens, 0=ones.
- o_Segments  output  8  raw segment byte of the last good frame.
- o_BCD  output  4  decoded digit of the last good frame.
- o_Value  output  14  binary value of the last complete scan.
- o_Value_Valid  output  1  one-cycle pulse: o_Value updated.
- o_Frame_Err  output  1  one-cycle pulse: framing violation.
- o_Decode_Err  output  1  one-cycle pulse: bad select or segment byte.

Behaviour:
- Clock and reset: one clock, i_CLK. i_RST is asynchronous and active-high.
- Reset values:
  - state=SYNC, bit counter=0, shift register=0, scan tracker=expect digit 3, digit regs=0.
  - o_Digit_Sel, o_Segments, o_BCD, o_Value = 0; all pulse outputs = 0.
  - Reset mid-frame or mid-scan discards all partial data.
- States:
  - SYNC: ignore i_Data until a cycle with i_Latch=0; the next cycle goes to SHIFT with count=0. This covers a partial first frame after reset.
  - SHIFT: each cycle shift i_Data into the shift register MSB-first, shifting right, so the first bit lands in sr[0] after 16 bits. Count increments.
- Frame completion:
  - i_Latch=0 with count=15 completes the frame: bits[7:0]=select, bits[15:8]=segments. Count returns to 0; state stays SHIFT.
  - i_Latch=0 with count!=15: pulse o_Frame_Err, drop the frame, reset the scan tracker. Count restarts at 0, since latch low realigns.
  - count=15 with i_Latch=1: pulse o_Frame_Err, reset the scan tracker, go to SYNC.
- Select decode:
  - 0x04→3, 0x08→2, 0x20→1, 0x40→0.
  - Any other value → o_Decode_Err.
- Segment decode: byte layout {dp,g,f,e,d,c,b,a}, dp ignored, active-high after the optional inversion.
  - 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x6F=9.
  - Any other pattern → o_Decode_Err.
- Timing of frame outputs: frame ends (latch low) in cycle N. In cycle N+1, either o_Frame_Valid pulses and o_Digit_Sel, o_Segments and o_BCD update, or o_Frame_Err / o_Decode_Err pulses. The error pulses are mutually exclusive with o_Frame_Valid.
- A decode error leaves the frame outputs at their previous values and resets the scan tracker.
- Scan tracking:
  - A good frame whose digit equals the expected digit stores its BCD and moves the expectation down (3→2→1→0).
  - A good frame with any other digit resets the expectation. If that frame's digit is 3, it is accepted as the start of a new scan.
- Scan completion: digit 0 accepted at N+1 → register th*1000+h*100+t*10+o. o_Value updates and o_Value_Valid pulses at N+2; the value is held until the next scan.
  - Maximum value is 9999, which fits 14 bits.
  - The multiply-add is a single registered stage.
- Back-to-back frames with no idle cycles are required and supported. The gap-free 64-cycle scan from the driver is the nominal case.

Test Plan:
- Reset, then send frames 0x0604, 0x5B08, 0x4F20, 0x6640 back-to-back, LSB first, latch low on each bit 15 → four o_Frame_Valid pulses with o_Digit_Sel 3,2,1,0 and o_BCD 1,2,3,4; o_Value=1234 with o_Value_Valid at 2 cycles after the last latch-low.
- Start the stream mid-frame (bit 7) after reset → no outputs until the first latch-low; the following full scan for 0x1FFF digits (8,1,9,1) gives o_Value=8191.
- Drive latch low at count=9 → o_Frame_Err one cycle later; the tracker resets; the next clean 4-frame scan still produces its value.
- Hold latch high for 17 bits → o_Frame_Err, SYNC; recovery on the next latch-low.
- Select byte 0x10, or segment byte 0x00 → o_Decode_Err, frame outputs unchanged, no o_Value_Valid for that scan.
- Assert i_RST asynchronously during frame 3 of a scan → all outputs 0 immediately; the rest of that scan produces no value.
- SEG_ACTIVE_LOW=1 with inverted segment bytes for 0,0,0,7 → o_Value=7.
